// File: rtl/multicycle_core.sv
// multicycle_core
//   Multi-cycle processor core. Each instruction walks FETCH -> DECODE ->
//   EXEC -> (MEM) -> (WB). Instruction and data memories are accessed with
//   req/ack handshakes, so either memory may take any number of cycles.
//   The core holds the PC, the link register, the GPR file (r0 reads zero),
//   the ALU and a combinational debug read port.
//
// Ports
//   clk, rstn          clock; asynchronous active-low reset
//   imem_req/addr      fetch request and word address (= pc)
//   imem_ack/rdata     fetch complete / instruction word
//   dmem_req/we        data request, 1 = store
//   dmem_addr/wdata    rs + sext(imm) / rt value for stores
//   dmem_ack/rdata     access complete / load data
//   program_counter    current pc
//   link_register      current lr
//   retire             one-cycle pulse per completed instruction
//   retired_cnt        completed-instruction count, wraps
//   halted             core stopped on an illegal instruction
//   regnum/reggg       debug register index / GPR[regnum]
//
// State   | meaning
// --------+------------------------------------------------------------
// S_FETCH | imem_req high, wait for imem_ack, latch instruction word
// S_DECODE| read rs/rt into operand registers
// S_EXEC  | ALU / address compute; branches and jumps retire here
// S_MEM   | dmem_req high, wait for dmem_ack; stores retire here
// S_WB    | write result to rd/rt, advance pc, retire
// S_HALT  | illegal instruction seen; only reset leaves this state
module multicycle_core #(
    parameter int               WIDTH    = 32,
    parameter int               NREG     = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int               CNT_W    = 32,
    localparam int              RW       = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rstn,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [WIDTH-1:0] dmem_addr,
    output logic [WIDTH-1:0] dmem_wdata,
    input  logic             dmem_ack,
    input  logic [WIDTH-1:0] dmem_rdata,
    output logic [WIDTH-1:0] program_counter,
    output logic [WIDTH-1:0] link_register,
    output logic             retire,
    output logic [CNT_W-1:0] retired_cnt,
    output logic             halted,
    input  logic [RW-1:0]    regnum,
    output logic [WIDTH-1:0] reggg
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;
    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_JR  = 6'h08;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] pc, pc_nxt;
    logic [WIDTH-1:0] lr, lr_nxt;
    logic [31:0]      ir;
    logic [WIDTH-1:0] op_a, op_b;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] addr_q;
    logic [WIDTH-1:0] gpr [NREG];
    logic             retire_c;

    // instruction fields
    logic [5:0]    opcode, funct;
    logic [RW-1:0] rs_idx, rt_idx, rd_idx, wr_idx;
    logic [4:0]    shamt;
    logic [15:0]   imm;
    logic [25:0]   jaddr;

    assign opcode = ir[31:26];
    assign rs_idx = ir[21 +: RW];
    assign rt_idx = ir[16 +: RW];
    assign rd_idx = ir[11 +: RW];
    assign shamt  = ir[10:6];
    assign funct  = ir[5:0];
    assign imm    = ir[15:0];
    assign jaddr  = ir[25:0];

    // instruction class decode
    logic is_alu_r, is_jr, is_addi, is_ori, is_lw, is_sw;
    logic is_beq, is_bne, is_j, is_jal, is_flow, legal;

    always_comb begin
        is_alu_r = 1'b0;
        is_jr    = 1'b0;
        is_addi  = 1'b0;
        is_ori   = 1'b0;
        is_lw    = 1'b0;
        is_sw    = 1'b0;
        is_beq   = 1'b0;
        is_bne   = 1'b0;
        is_j     = 1'b0;
        is_jal   = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_SLL: is_alu_r = 1'b1;
                    FN_JR:   is_jr = 1'b1;
                    default: ;
                endcase
            end
            OP_ADDI: is_addi = 1'b1;
            OP_ORI:  is_ori  = 1'b1;
            OP_LW:   is_lw   = 1'b1;
            OP_SW:   is_sw   = 1'b1;
            OP_BEQ:  is_beq  = 1'b1;
            OP_BNE:  is_bne  = 1'b1;
            OP_J:    is_j    = 1'b1;
            OP_JAL:  is_jal  = 1'b1;
            default: ;
        endcase
    end

    assign is_flow = is_beq | is_bne | is_j | is_jal | is_jr;
    assign legal   = is_alu_r | is_addi | is_ori | is_lw | is_sw | is_flow;

    // register file read ports; r0 is never written so it always reads zero
    logic [WIDTH-1:0] rs_val, rt_val;

    always_comb begin
        rs_val = '0;
        rt_val = '0;
        reggg  = '0;
        if (int'(rs_idx) < NREG) rs_val = gpr[rs_idx];
        if (int'(rt_idx) < NREG) rt_val = gpr[rt_idx];
        if (int'(regnum) < NREG) reggg  = gpr[regnum];
    end

    // execute-stage arithmetic
    logic [WIDTH-1:0] sext_imm, zext_imm, pc_inc, br_target, mem_addr;
    logic [WIDTH-1:0] alu_res, flow_target;

    assign sext_imm  = {{(WIDTH-16){imm[15]}}, imm};
    assign zext_imm  = {{(WIDTH-16){1'b0}}, imm};
    assign pc_inc    = pc + WIDTH'(1);
    assign br_target = pc_inc + sext_imm;
    assign mem_addr  = op_a + sext_imm;

    always_comb begin
        alu_res = '0;
        if (is_alu_r) begin
            case (funct)
                FN_ADD:  alu_res = op_a + op_b;
                FN_SUB:  alu_res = op_a - op_b;
                FN_AND:  alu_res = op_a & op_b;
                FN_OR:   alu_res = op_a | op_b;
                FN_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
                FN_SLL:  alu_res = op_b << shamt;
                default: alu_res = '0;
            endcase
        end else if (is_addi) begin
            alu_res = op_a + sext_imm;
        end else if (is_ori) begin
            alu_res = op_a | zext_imm;
        end
    end

    // j/jal keep the upper bits of pc+1 and replace the low 26 with the target
    always_comb begin
        flow_target = pc_inc;
        if (is_jr) begin
            flow_target = op_a;
        end else if (is_j || is_jal) begin
            flow_target        = pc_inc;
            flow_target[25:0]  = jaddr;
        end else if ((is_beq && (op_a == op_b)) || (is_bne && (op_a != op_b))) begin
            flow_target = br_target;
        end
    end

    // next state, pc, lr and retire
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        lr_nxt    = lr;
        retire_c  = 1'b0;
        case (state)
            S_FETCH: begin
                if (imem_ack) state_nxt = S_DECODE;
            end
            S_DECODE: state_nxt = S_EXEC;
            S_EXEC: begin
                if (!legal) begin
                    state_nxt = S_HALT;
                end else if (is_lw || is_sw) begin
                    state_nxt = S_MEM;
                end else if (is_flow) begin
                    pc_nxt    = flow_target;
                    retire_c  = 1'b1;
                    state_nxt = S_FETCH;
                    if (is_jal) lr_nxt = pc_inc;
                end else begin
                    state_nxt = S_WB;
                end
            end
            S_MEM: begin
                if (dmem_ack) begin
                    if (is_sw) begin
                        pc_nxt    = pc_inc;
                        retire_c  = 1'b1;
                        state_nxt = S_FETCH;
                    end else begin
                        state_nxt = S_WB;
                    end
                end
            end
            S_WB: begin
                pc_nxt    = pc_inc;
                retire_c  = 1'b1;
                state_nxt = S_FETCH;
            end
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= S_FETCH;
            pc          <= RESET_PC;
            lr          <= '0;
            ir          <= '0;
            op_a        <= '0;
            op_b        <= '0;
            res_q       <= '0;
            addr_q      <= '0;
            retired_cnt <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            lr    <= lr_nxt;
            if (state == S_FETCH && imem_ack) ir <= imem_rdata;
            if (state == S_DECODE) begin
                op_a <= rs_val;
                op_b <= rt_val;
            end
            if (state == S_EXEC) begin
                res_q  <= alu_res;
                addr_q <= mem_addr;
            end
            if (state == S_MEM && dmem_ack && !is_sw) res_q <= dmem_rdata;
            if (retire_c) retired_cnt <= retired_cnt + CNT_W'(1);
        end
    end

    // GPR write port; writes to r0 are dropped here
    assign wr_idx = is_alu_r ? rd_idx : rt_idx;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NREG; i++) gpr[i] <= '0;
        end else if (state == S_WB && wr_idx != '0 && int'(wr_idx) < NREG) begin
            gpr[wr_idx] <= res_q;
        end
    end

    // the reset term drops the fetch request the moment rstn falls,
    // even though the state register sits at S_FETCH during reset
    assign imem_req        = rstn && (state == S_FETCH);
    assign imem_addr       = pc;
    assign dmem_req        = (state == S_MEM);
    assign dmem_we         = (state == S_MEM) && is_sw;
    assign dmem_addr       = addr_q;
    assign dmem_wdata      = op_b;
    assign program_counter = pc;
    assign link_register   = lr;
    assign retire          = retire_c;
    assign halted          = (state == S_HALT);

endmodule

// File: tb/tb_multicycle_core.sv
// Directed testbench for multicycle_core: instruction/data memory models
// with programmable ack delay, a negedge event logger, and a linear
// sequence of directed programs with hand-computed results.
module tb_multicycle_core;

    localparam logic [31:0] ILL = 32'hFC00_0000;

    logic        clk  = 1'b0;
    logic        rstn = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic [31:0] program_counter;
    logic [31:0] link_register;
    logic        retire;
    logic [31:0] retired_cnt;
    logic        halted;
    logic [4:0]  regnum = '0;
    logic [31:0] reggg;

    int checks = 0;
    int errors = 0;
    int imem_wait = 0;
    int dmem_wait = 0;
    int icnt = 0;
    int dcnt = 0;
    int cyc = 0;

    logic [31:0] imem [256];
    logic [31:0] dmem [256] = '{default: '0};

    multicycle_core dut (
        .clk             (clk),
        .rstn            (rstn),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .dmem_req        (dmem_req),
        .dmem_we         (dmem_we),
        .dmem_addr       (dmem_addr),
        .dmem_wdata      (dmem_wdata),
        .dmem_ack        (dmem_ack),
        .dmem_rdata      (dmem_rdata),
        .program_counter (program_counter),
        .link_register   (link_register),
        .retire          (retire),
        .retired_cnt     (retired_cnt),
        .halted          (halted),
        .regnum          (regnum),
        .reggg           (reggg)
    );

    always #5 clk = ~clk;

    // memory models: ack after N wait cycles of a continuously held request
    assign imem_ack   = imem_req && (icnt >= imem_wait);
    assign imem_rdata = imem[imem_addr[7:0]];
    assign dmem_ack   = dmem_req && (dcnt >= dmem_wait);
    assign dmem_rdata = dmem[dmem_addr[7:0]];

    always @(posedge clk) begin
        icnt <= (imem_req && !imem_ack) ? icnt + 1 : 0;
        dcnt <= (dmem_req && !dmem_ack) ? dcnt + 1 : 0;
        cyc  <= rstn ? cyc + 1 : 0;
        if (dmem_req && dmem_we && dmem_ack) dmem[dmem_addr[7:0]] <= dmem_wdata;
    end

    // event logger: cycle numbers count from 1 = first cycle after release
    int          ret_q[$];
    logic [31:0] fetch_q[$];
    logic        dwe_q[$];
    logic [31:0] daddr_q[$];
    logic [31:0] dwdata_q[$];
    int          i_unstable = 0;
    int          d_unstable = 0;
    logic        i_wait = 1'b0;
    logic        d_wait = 1'b0;
    logic [31:0] i_prev = '0;
    logic [64:0] d_prev = '0;

    always @(negedge clk) begin
        if (!rstn) begin
            ret_q.delete();
            fetch_q.delete();
            dwe_q.delete();
            daddr_q.delete();
            dwdata_q.delete();
            i_unstable = 0;
            d_unstable = 0;
            i_wait     = 1'b0;
            d_wait     = 1'b0;
        end else begin
            if (retire) ret_q.push_back(cyc + 1);
            if (imem_req && imem_ack) fetch_q.push_back(imem_addr);
            if (dmem_req && dmem_ack) begin
                dwe_q.push_back(dmem_we);
                daddr_q.push_back(dmem_addr);
                dwdata_q.push_back(dmem_wdata);
            end
            if (i_wait && imem_addr != i_prev) i_unstable++;
            if (d_wait && {dmem_we, dmem_addr, dmem_wdata} != d_prev) d_unstable++;
            i_wait = imem_req && !imem_ack;
            i_prev = imem_addr;
            d_wait = dmem_req && !dmem_ack;
            d_prev = {dmem_we, dmem_addr, dmem_wdata};
        end
    end

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd,
                                          input int sh, input int fn);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
    endfunction

    function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] enc_j(input int op, input int addr);
        return {6'(op), 26'(addr)};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 256; i++) imem[i] = ILL;
    endtask

    // release lands 1 time unit after a posedge, so the next negedge is cycle 1
    task automatic do_reset();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    task automatic wait_halt(input string tag, input int max_cycles);
        for (int k = 0; k < max_cycles && !halted; k++) @(negedge clk);
        check(tag, halted, 1);
    endtask

    task automatic read_reg(input int n, output logic [31:0] v);
        regnum = 5'(n);
        #1 v = reggg;
    endtask

    initial begin
        logic [31:0] v;
        int          req_seen;
        logic [31:0] exp_f [8];

        // ---------------- reset values
        #2 rstn = 1'b0;
        #1;
        check("rst_imem_req", imem_req, 0);
        check("rst_imem_addr", imem_addr, 0);
        check("rst_pc_lr", {program_counter, link_register}, 0);
        check("rst_cnt_halt_retire", {retired_cnt, halted, retire}, 0);
        check("rst_dmem", {dmem_req, dmem_we, dmem_addr, dmem_wdata}, 0);

        // ---------------- test 1: addi/addi/add, zero-wait
        clear_imem();
        imem[0] = enc_i('h08, 0, 1, 5);
        imem[1] = enc_i('h08, 0, 2, -3);
        imem[2] = enc_r(1, 2, 3, 0, 'h20);
        do_reset();
        regnum = 5'd1;
        repeat (4) @(negedge clk);
        check("t1_retire_cycle4", retire, 1);
        check("t1_r1_during_wb", reggg, 0);
        @(negedge clk);
        check("t1_r1_after_wb", reggg, 5);
        check("t1_cnt_after_first", retired_cnt, 1);
        wait_halt("t1_halt", 100);
        check("t1_ret0", ret_q[0], 4);
        check("t1_ret1", ret_q[1], 8);
        check("t1_ret2", ret_q[2], 12);
        check("t1_retired_cnt", retired_cnt, 3);
        read_reg(3, v);
        check("t1_r3", v, 2);
        read_reg(2, v);
        check("t1_r2", v, 32'hFFFF_FFFD);
        check("t1_pc_halt", program_counter, 3);

        // ---------------- test 2: 3 wait cycles per fetch
        clear_imem();
        imem[0] = enc_i('h08, 0, 1, 5);
        imem_wait = 3;
        do_reset();
        wait_halt("t2_halt", 100);
        check("t2_ret0", ret_q[0], 7);
        check("t2_imem_addr_stable", i_unstable, 0);
        read_reg(1, v);
        check("t2_r1", v, 5);
        check("t2_fetch1", fetch_q[1], 1);
        imem_wait = 0;

        // ---------------- test 3: sw then lw with 2-cycle dmem ack
        clear_imem();
        imem[0] = enc_i('h08, 0, 1, 5);
        imem[1] = enc_i('h2B, 0, 1, 4);
        imem[2] = enc_i('h23, 0, 4, 4);
        dmem_wait = 2;
        do_reset();
        wait_halt("t3_halt", 100);
        check("t3_ret_addi", ret_q[0], 4);
        check("t3_ret_sw", ret_q[1], 10);
        check("t3_ret_lw", ret_q[2], 17);
        check("t3_we0", dwe_q[0], 1);
        check("t3_we1", dwe_q[1], 0);
        check("t3_addr0", daddr_q[0], 4);
        check("t3_addr1", daddr_q[1], 4);
        check("t3_wdata0", dwdata_q[0], 5);
        check("t3_dmem_stable", d_unstable, 0);
        check("t3_mem4", dmem[4], 5);
        read_reg(4, v);
        check("t3_r4", v, 5);
        dmem_wait = 0;

        // ---------------- test 4a: beq r1,r1,-1 at pc 10 loops on itself
        clear_imem();
        imem[0]  = enc_i('h08, 0, 1, 5);
        imem[1]  = enc_j('h02, 10);
        imem[10] = enc_i('h04, 1, 1, -1);
        do_reset();
        for (int k = 0; k < 60 && fetch_q.size() < 5; k++) @(negedge clk);
        check("t4a_fetch_count", fetch_q.size() >= 5, 1);
        check("t4a_fetch2", fetch_q[2], 10);
        check("t4a_fetch3", fetch_q[3], 10);
        check("t4a_fetch4", fetch_q[4], 10);

        // ---------------- test 4b: bne not taken, jal, jr
        clear_imem();
        imem[0]    = enc_i('h08, 0, 1, 5);
        imem[1]    = enc_j('h02, 10);
        imem[10]   = enc_i('h05, 1, 1, 7);
        imem[11]   = enc_j('h02, 20);
        imem[20]   = enc_j('h03, 'h40);
        imem['h40] = enc_i('h08, 0, 31, 3);
        imem['h41] = enc_r(31, 0, 0, 0, 'h08);
        exp_f = '{32'd0, 32'd1, 32'd10, 32'd11, 32'd20, 32'h40, 32'h41, 32'd3};
        do_reset();
        wait_halt("t4b_halt", 200);
        for (int k = 0; k < 8; k++) check($sformatf("t4b_fetch%0d", k), fetch_q[k], exp_f[k]);
        check("t4b_lr", link_register, 21);
        check("t4b_ret_jal", ret_q[4], 16);
        check("t4b_ret_jr", ret_q[6], 23);
        check("t4b_retired_cnt", retired_cnt, 7);
        read_reg(31, v);
        check("t4b_r31", v, 3);
        check("t4b_pc_halt", program_counter, 3);

        // ---------------- test 5: r0 write, sll, slt, logic ops, sub
        clear_imem();
        imem[0]  = enc_i('h08, 0, 1, 5);
        imem[1]  = enc_i('h08, 0, 2, -3);
        imem[2]  = enc_i('h08, 0, 0, 9);
        imem[3]  = enc_r(0, 1, 5, 4, 'h00);
        imem[4]  = enc_i('h08, 0, 7, -1);
        imem[5]  = enc_i('h08, 0, 8, 1);
        imem[6]  = enc_r(7, 8, 6, 0, 'h2A);
        imem[7]  = enc_r(8, 7, 9, 0, 'h2A);
        imem[8]  = enc_i('h0D, 0, 13, 'h8001);
        imem[9]  = enc_r(2, 13, 11, 0, 'h24);
        imem[10] = enc_r(1, 13, 12, 0, 'h25);
        imem[11] = enc_r(1, 2, 10, 0, 'h22);
        do_reset();
        wait_halt("t5_halt", 300);
        read_reg(0, v);
        check("t5_r0", v, 0);
        read_reg(5, v);
        check("t5_sll_r5", v, 80);
        read_reg(6, v);
        check("t5_slt_neg_pos", v, 1);
        read_reg(9, v);
        check("t5_slt_pos_neg", v, 0);
        read_reg(13, v);
        check("t5_ori_zext", v, 32'h0000_8001);
        read_reg(11, v);
        check("t5_and", v, 32'h0000_8001);
        read_reg(12, v);
        check("t5_or", v, 32'h0000_8005);
        read_reg(10, v);
        check("t5_sub", v, 8);
        check("t5_retired_cnt", retired_cnt, 12);

        // ---------------- test 6: halt is absorbing, reset mid-fetch
        req_seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (imem_req) req_seen++;
        end
        check("t6_no_req_halted", req_seen, 0);
        check("t6_pc_frozen", program_counter, 12);
        check("t6_still_halted", halted, 1);

        clear_imem();
        imem[0] = enc_j('h02, 30);
        imem_wait = 5;
        do_reset();
        repeat (10) @(negedge clk);
        check("t6_wait_req", imem_req, 1);
        check("t6_wait_addr", imem_addr, 30);
        #1 rstn = 1'b0;
        #1;
        check("t6_rst_req_drop", imem_req, 0);
        check("t6_rst_pc", program_counter, 0);
        check("t6_rst_addr", imem_addr, 0);
        imem_wait = 0;
        do_reset();
        @(negedge clk);
        check("t6_restart_fetch", {imem_req, imem_addr}, {1'b1, 32'd0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_core.md
Name: multicycle_core

Overview:
- Parametrised multi-cycle successor to the single-cycle core top.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB with req/ack handshakes on instruction and data memory, so both memories may have arbitrary latency.
- Contains the PC, the link register, the GPR file (r0 hardwired zero), the ALU subset and the debug register read port.
- Sits between the instruction BRAM/loader and the data memory/IO arbiter.

Parameters:
- WIDTH, 32: datapath, register and address width (>=26).
- NREG, 32: number of GPRs; index width RW = clog2(NREG), max 32.
- RESET_PC, 0: PC value after reset (word address).
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  WIDTH  fetch word address (= pc).
- imem_ack  in  1  instruction valid this cycle.
- imem_rdata  in  32  instruction word.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = store, 0 = load; valid with dmem_req.
- dmem_addr  out  WIDTH  rs + sext(imm).
- dmem_wdata  out  WIDTH  rt value for stores.
- dmem_ack  in  1  access complete; load data valid this cycle.
- dmem_rdata  in  WIDTH  load data.
- program_counter  out  WIDTH  current pc.
- link_register  out  WIDTH  current lr.
- retire  out  1  one-cycle pulse per completed instruction.
- retired_cnt  out  CNT_W  retired instructions, wraps modulo 2^CNT_W.
- halted  out  1  core stopped on an illegal instruction.
- regnum  in  RW  debug register index.
- reggg  out  WIDTH  combinational read of GPR[regnum].

Behaviour:
- Reset (async assert, sync release): state = FETCH, pc = RESET_PC, lr = 0, all GPRs 0, instruction register 0, retired_cnt 0, all outputs 0 except imem_addr = RESET_PC. Reset mid-handshake aborts it; requests drop immediately.
- Encoding: op[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6], funct[5:0], imm[15:0], addr[25:0]. Register fields use the low RW bits.
- Opcodes:
  - op 0 (R-type), by funct: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt (signed), 0x00 sll rt by shamt, 0x08 jr.
  - I/J-type: 0x08 addi (sext), 0x0D ori (zext), 0x23 lw, 0x2B sw, 0x04 beq, 0x05 bne, 0x02 j, 0x03 jal.
  - Any other op/funct is illegal.
- Arithmetic: add/sub wrap modulo 2^WIDTH; no overflow trap.
- FETCH:
  - imem_req = 1, imem_addr = pc, held stable until imem_ack.
  - An ack in the same cycle as the first req is legal.
  - On ack, latch imem_rdata and go to DECODE.
- DECODE (1 cycle): read rs and rt into operand registers; go to EXEC.
- EXEC (1 cycle):
  - ALU ops and addi/ori: compute result, go to WB.
  - lw/sw: compute address, go to MEM.
  - beq/bne taken: pc = pc+1+sext(imm). Not taken: pc = pc+1.
  - j: pc = {(pc+1)[WIDTH-1:26], addr}.
  - jal: same target as j, and lr = pc+1.
  - jr: pc = rs value.
  - Branches and jumps assert retire and go to FETCH.
  - Illegal: go to HALT; no retire, pc unchanged.
- MEM:
  - dmem_req = 1; dmem_we, dmem_addr and dmem_wdata held stable until dmem_ack.
  - Load ack: latch dmem_rdata, go to WB.
  - Store ack: pc = pc+1, retire, go to FETCH.
- WB (1 cycle): write rd (R-type) or rt (addi/ori/lw), pc = pc+1, retire, go to FETCH.
- Register writes: any write to r0 is discarded; r0 always reads 0.
- Debug read: a WB write becomes visible on reggg the cycle after WB.
- HALT: absorbing state; halted = 1, no requests. Only reset exits.
- Latency with zero-wait acks:
  - ALU/imm ops: 4 cycles.
  - Branch/jump: 3 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - Each wait cycle on an ack adds one cycle.
- Acks that arrive while the matching req is low are ignored.
- retire is high for exactly one cycle per instruction; retired_cnt increments in the same cycle.

Test Plan:
- Reset, ack tied 1; program addi r1,r0,5 ; addi r2,r0,-3 ; add r3,r1,r2 -> r3 = 2; retire pulses at cycles 4, 8, 12; retired_cnt = 3.
- imem_ack delayed 3 cycles per fetch -> imem_addr stable throughout each wait; addi completes in 7 cycles; result unchanged.
- sw r1,4(r0) then lw r4,4(r0), with a memory model and 2-cycle dmem_ack -> dmem_we 1 then 0; dmem_addr = 4; r4 = 5.
- Branches and links:
  - beq r1,r1,-1 at pc 10 -> next fetch addr 10.
  - bne r1,r1,+7 -> next fetch 11.
  - jal 0x40 at pc 20 -> lr = 21, next fetch 0x40.
  - jr r31 with r31 = 3 -> next fetch 3.
- addi r0,r0,9 -> reggg with regnum = 0 reads 0. sll r5,r1,4 with r1 = 5 -> r5 = 80. slt with -1 vs 1 -> 1.
- Fetch op 0x3F -> halted = 1, no further imem_req, pc frozen; assert rstn low mid-FETCH -> pc = RESET_PC and imem_req = 0 immediately.
